// File: rtl/store_queue_mp_if.sv
// D-cache store request channel between the store queue (master) and the cache (slave).
interface store_queue_mp_if #(
  parameter int DATA_BYTES = 4
);
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [31:0]             mem_req_addr;
  logic [8*DATA_BYTES-1:0] mem_req_data;
  logic [DATA_BYTES-1:0]   mem_req_mask;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_data, mem_req_mask,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_mask,
    output mem_req_ready
  );
endinterface

// File: rtl/store_queue_mp.sv
// Multi-port store queue: superscalar allocate/retire, in-order drain to the D-cache,
// per-load-port youngest-match byte forwarding and mispredict tail restore.
module store_queue_mp #(
  parameter  int SQ_DEPTH   = 8,
  parameter  int DISP_W     = 2,
  parameter  int RET_W      = 2,
  parameter  int LD_PORTS   = 2,
  parameter  int DATA_BYTES = 4,
  localparam int IDX        = $clog2(SQ_DEPTH),
  localparam int PTR        = IDX + 1,
  localparam int DC         = $clog2(DISP_W + 1),
  localparam int RC         = $clog2(RET_W + 1),
  localparam int W          = 8 * DATA_BYTES
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DC-1:0]                disp_count,
  output logic [DC-1:0]                sq_spots,
  output logic [PTR-1:0]               sq_tail,
  output logic                         full,
  output logic                         empty,
  input  logic                         res_valid,
  input  logic [IDX-1:0]               res_idx,
  input  logic [31:0]                  res_addr,
  input  logic [W-1:0]                 res_data,
  input  logic [DATA_BYTES-1:0]        res_mask,
  input  logic [RC-1:0]                ret_count,
  input  logic [LD_PORTS*PTR-1:0]      ld_tail,
  input  logic [LD_PORTS*32-1:0]       ld_addr,
  output logic [LD_PORTS*W-1:0]        ld_data,
  output logic [LD_PORTS*DATA_BYTES-1:0] ld_fwd_mask,
  output logic [LD_PORTS-1:0]          ld_stall,
  input  logic                         restore_valid,
  input  logic [PTR-1:0]               restore_tail,
  store_queue_mp_if.master             mem
);
  localparam int OFFB = $clog2(DATA_BYTES);

  logic [PTR-1:0]        tail_q, tail_d, ret_q, ret_d, head_q, head_d;
  logic [SQ_DEPTH-1:0]   resolved_q, resolved_d;
  logic [31:0]           addr_q [SQ_DEPTH];
  logic [W-1:0]          data_q [SQ_DEPTH];
  logic [DATA_BYTES-1:0] mask_q [SQ_DEPTH];

  logic [PTR-1:0] occ, free_cnt, res_span;
  logic [IDX-1:0] res_off;
  logic [DC-1:0]  alloc;
  logic           res_ok, drain;
  logic           ld_addr_unused;

  assign occ      = tail_q - head_q;
  assign free_cnt = PTR'(SQ_DEPTH) - occ;
  assign full     = (occ == PTR'(SQ_DEPTH));
  assign empty    = (occ == '0);
  assign sq_spots = (32'(free_cnt) < DISP_W) ? DC'(free_cnt) : DC'(DISP_W);
  assign sq_tail  = tail_q;
  assign alloc    = (disp_count < sq_spots) ? disp_count : sq_spots;

  // A resolve is live only inside [retire_ptr, tail); a same-cycle restore shrinks that range.
  assign res_off  = res_idx - ret_q[IDX-1:0];
  assign res_span = (restore_valid ? restore_tail : tail_q) - ret_q;
  assign res_ok   = res_valid && ({1'b0, res_off} < res_span);

  assign mem.mem_req_valid = (ret_q != head_q);
  assign mem.mem_req_addr  = addr_q[head_q[IDX-1:0]];
  assign mem.mem_req_data  = data_q[head_q[IDX-1:0]];
  assign mem.mem_req_mask  = mask_q[head_q[IDX-1:0]];
  assign drain             = mem.mem_req_valid && mem.mem_req_ready;

  always_comb begin
    resolved_d = resolved_q;
    ret_d      = ret_q + PTR'(ret_count);
    head_d     = head_q + PTR'(drain);
    tail_d     = tail_q;
    if (restore_valid) begin
      tail_d = restore_tail;
    end else begin
      tail_d = tail_q + PTR'(alloc);
      for (int k = 0; k < DISP_W; k++) begin
        if (k < int'(alloc)) resolved_d[tail_q[IDX-1:0] + IDX'(k)] = 1'b0;
      end
    end
    if (res_ok) resolved_d[res_idx] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tail_q     <= '0;
      ret_q      <= '0;
      head_q     <= '0;
      resolved_q <= '0;
    end else begin
      tail_q     <= tail_d;
      ret_q      <= ret_d;
      head_q     <= head_d;
      resolved_q <= resolved_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && res_ok) begin
      addr_q[res_idx] <= res_addr;
      data_q[res_idx] <= res_data;
      mask_q[res_idx] <= res_mask;
    end
  end

  assign ld_addr_unused = ^ld_addr;

  // Walk the window oldest to youngest so the youngest matching byte wins.
  for (genvar gi = 0; gi < LD_PORTS; gi++) begin : g_ld
    logic [PTR-1:0]        win;
    logic [IDX-1:0]        e;
    logic [W-1:0]          fdata;
    logic [DATA_BYTES-1:0] fmask;
    logic                  fstall;

    assign win = ld_tail[gi*PTR +: PTR] - head_q;

    always_comb begin
      fdata  = '0;
      fmask  = '0;
      fstall = 1'b0;
      e      = '0;
      for (int k = 0; k < SQ_DEPTH; k++) begin
        e = head_q[IDX-1:0] + IDX'(k);
        if (PTR'(k) < win) begin
          if (!resolved_q[e]) begin
            fstall = 1'b1;
          end else if (addr_q[e][31:OFFB] == ld_addr[gi*32+OFFB +: 32-OFFB]) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
              if (mask_q[e][b]) begin
                fdata[8*b +: 8] = data_q[e][8*b +: 8];
                fmask[b]        = 1'b1;
              end
            end
          end
        end
      end
    end

    assign ld_data[gi*W +: W]                      = fdata;
    assign ld_fwd_mask[gi*DATA_BYTES +: DATA_BYTES] = fmask;
    assign ld_stall[gi]                            = fstall;
  end
endmodule

// File: tb/tb_store_queue_mp.sv
// Scoreboard bench for store_queue_mp: a queue-of-entries reference model predicts
// every cycle's outputs and the drained store stream; monitors compare on the falling edge.
module tb_store_queue_mp;
  localparam int SQ_DEPTH = 8, DISP_W = 2, RET_W = 2, LD_PORTS = 2, DATA_BYTES = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  disp_count, sq_spots, ret_count, ld_stall;
  logic [3:0]  sq_tail, res_mask, restore_tail;
  logic        full, empty, res_valid, restore_valid;
  logic [2:0]  res_idx;
  logic [31:0] res_addr, res_data;
  logic [7:0]  ld_tail, ld_fwd_mask;
  logic [63:0] ld_addr, ld_data;

  store_queue_mp_if #(.DATA_BYTES(DATA_BYTES)) mem_if ();

  store_queue_mp #(
    .SQ_DEPTH(SQ_DEPTH), .DISP_W(DISP_W), .RET_W(RET_W),
    .LD_PORTS(LD_PORTS), .DATA_BYTES(DATA_BYTES)
  ) dut (
    .clock(clock), .reset(reset), .disp_count(disp_count), .sq_spots(sq_spots),
    .sq_tail(sq_tail), .full(full), .empty(empty), .res_valid(res_valid),
    .res_idx(res_idx), .res_addr(res_addr), .res_data(res_data), .res_mask(res_mask),
    .ret_count(ret_count), .ld_tail(ld_tail), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_fwd_mask(ld_fwd_mask), .ld_stall(ld_stall), .restore_valid(restore_valid),
    .restore_tail(restore_tail), .mem(mem_if)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          res;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } ent_t;

  typedef struct {
    logic [3:0]  tail;
    logic        full;
    logic        empty;
    logic [1:0]  spots;
    logic        mv;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic [3:0]  mmask;
    logic [63:0] ldd;
    logic [7:0]  ldm;
    logic [1:0]  lds;
  } exp_t;

  ent_t sq[$];        // sq[0] sits at drain_head; first n_com entries are committed
  ent_t exp_mem[$];   // stores expected on the D-cache port, in order
  exp_t exp_q[$];
  int   n_com, head_p;
  int   n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tail_p();
    return (head_p + sq.size()) % 16;
  endfunction

  function automatic int ret_p();
    return (head_p + n_com) % 16;
  endfunction

  function automatic int max_ret();
    int mr;
    mr = 0;
    while (mr < RET_W && n_com + mr < sq.size() && sq[n_com+mr].res) mr++;
    return mr;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] base;
    case ($urandom_range(0, 2))
      0:       base = 32'h100;
      1:       base = 32'h104;
      default: base = 32'h200;
    endcase
    return base | 32'($urandom_range(0, 3));
  endfunction

  function automatic exp_t predict();
    exp_t e;
    int   occ;
    occ     = sq.size();
    e.tail  = 4'(tail_p());
    e.full  = (occ == SQ_DEPTH);
    e.empty = (occ == 0);
    e.spots = 2'((SQ_DEPTH - occ < DISP_W) ? SQ_DEPTH - occ : DISP_W);
    e.mv    = (n_com > 0);
    e.maddr = '0; e.mdata = '0; e.mmask = '0;
    if (e.mv) begin
      e.maddr = sq[0].addr; e.mdata = sq[0].data; e.mmask = sq[0].mask;
    end
    e.ldd = '0; e.ldm = '0; e.lds = '0;
    for (int p = 0; p < LD_PORTS; p++) begin
      int          wl;
      logic [31:0] la;
      wl = (int'(ld_tail[p*4 +: 4]) - head_p + 16) % 16;
      la = ld_addr[p*32 +: 32];
      for (int k = 0; k < wl && k < occ; k++) begin
        if (!sq[k].res) e.lds[p] = 1'b1;
        else if (sq[k].addr[31:2] == la[31:2]) begin
          for (int b = 0; b < 4; b++) begin
            if (sq[k].mask[b]) begin
              e.ldd[p*32 + 8*b +: 8] = sq[k].data[8*b +: 8];
              e.ldm[p*4 + b]         = 1'b1;
            end
          end
        end
      end
    end
    return e;
  endfunction

  task automatic model_reset();
    sq.delete();
    exp_mem.delete();
    n_com  = 0;
    head_p = 0;
  endtask

  // Applies the inputs present at the rising edge to the reference model.
  task automatic model_update();
    int   old_com, uncom, retp, off, span, nl, spots, a;
    ent_t blank;
    if (!reset) begin
      model_reset();
      return;
    end
    old_com = n_com;
    uncom   = sq.size() - n_com;
    retp    = ret_p();
    if (res_valid) begin
      off  = (int'(res_idx) - retp % 8 + 8) % 8;
      span = restore_valid ? (int'(restore_tail) - retp + 16) % 16 : uncom;
      if (off < span) sq[n_com+off] = '{1'b1, res_addr, res_data, res_mask};
    end
    if (restore_valid) begin
      nl = (int'(restore_tail) - head_p + 16) % 16;
      if (nl > sq.size() || nl < n_com + int'(ret_count)) begin
        n_fail++;
        $display("FAIL illegal_restore: restore_tail 0x%0h outside [retire, tail]", restore_tail);
      end
      while (sq.size() > nl) void'(sq.pop_back());
    end else begin
      spots = (SQ_DEPTH - sq.size() < DISP_W) ? SQ_DEPTH - sq.size() : DISP_W;
      a     = (int'(disp_count) < spots) ? int'(disp_count) : spots;
      blank = '{1'b0, 32'h0, 32'h0, 4'h0};
      repeat (a) sq.push_back(blank);
    end
    for (int r = 0; r < int'(ret_count); r++) begin
      if (n_com >= sq.size() || !sq[n_com].res) begin
        n_fail++;
        $display("FAIL illegal_retire: retiring unresolved or beyond tail");
      end else begin
        exp_mem.push_back(sq[n_com]);
        n_com++;
      end
    end
    if (old_com > 0 && mem_if.mem_req_ready) begin
      void'(sq.pop_front());
      n_com--;
      head_p = (head_p + 1) % 16;
    end
  endtask

  task automatic cycle();
    exp_q.push_back(predict());
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    disp_count = 0; res_valid = 0; res_idx = 0; res_addr = 0; res_data = 0;
    res_mask = 0; ret_count = 0; restore_valid = 0; restore_tail = 0;
  endtask

  always @(negedge clock) begin
    exp_t e;
    ent_t m;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sq_tail", 64'(sq_tail), 64'(e.tail));
      check("full", 64'(full), 64'(e.full));
      check("empty", 64'(empty), 64'(e.empty));
      check("sq_spots", 64'(sq_spots), 64'(e.spots));
      check("mem_req_valid", 64'(mem_if.mem_req_valid), 64'(e.mv));
      if (e.mv) begin
        check("mem_req_addr", 64'(mem_if.mem_req_addr), 64'(e.maddr));
        check("mem_req_data", 64'(mem_if.mem_req_data), 64'(e.mdata));
        check("mem_req_mask", 64'(mem_if.mem_req_mask), 64'(e.mmask));
      end
      check("ld_data", ld_data, e.ldd);
      check("ld_fwd_mask", 64'(ld_fwd_mask), 64'(e.ldm));
      check("ld_stall", 64'(ld_stall), 64'(e.lds));
    end
    if (reset && mem_if.mem_req_valid && mem_if.mem_req_ready) begin
      if (exp_mem.size() == 0) begin
        check("drain_unexpected", 64'(1), 64'(0));
      end else begin
        m = exp_mem.pop_front();
        check("drain_addr", 64'(mem_if.mem_req_addr), 64'(m.addr));
        check("drain_data", 64'(mem_if.mem_req_data), 64'(m.data));
        check("drain_mask", 64'(mem_if.mem_req_mask), 64'(m.mask));
      end
    end
  end

  initial begin
    int sz, uncom, retp, mr;
    idle();
    mem_if.mem_req_ready = 1'b0;
    ld_tail = '0;
    ld_addr = '0;
    reset   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    reset = 1'b1;
    #1;
    check("rst_sq_tail", 64'(sq_tail), 64'h0);
    check("rst_empty", 64'(empty), 64'h1);
    check("rst_full", 64'(full), 64'h0);
    check("rst_spots", 64'(sq_spots), 64'h2);
    check("rst_mem_valid", 64'(mem_if.mem_req_valid), 64'h0);
    check("rst_ld", {ld_data[31:0], 22'h0, ld_fwd_mask, ld_stall}, 64'h0);

    // Fill: four double dispatches, fifth dropped
    disp_count = 2;
    repeat (4) cycle();
    check("fill_tail", 64'(sq_tail), 64'h8);
    check("fill_full", 64'(full), 64'h1);
    check("fill_spots", 64'(sq_spots), 64'h0);
    cycle();
    idle();
    check("drop_tail", 64'(sq_tail), 64'h8);

    // Resolve entry0; entry1 still unresolved stalls port1
    ld_tail[7:4] = 4'd2;
    res_valid = 1; res_idx = 0; res_addr = 32'h100; res_data = 32'h11223344; res_mask = 4'hF;
    cycle();
    res_idx = 1; res_data = 32'hAABBCCDD; res_mask = 4'h3;
    #1;
    check("stall_before_resolve", 64'(ld_stall[1]), 64'h1);
    cycle();
    idle();
    check("stall_after_resolve", 64'(ld_stall[1]), 64'h0);

    // Youngest-match forwarding through port0
    ld_tail[3:0] = 4'd2;
    ld_addr[31:0] = 32'h102;
    #1;
    check("fwd_young_data", 64'(ld_data[31:0]), 64'h1122CCDD);
    check("fwd_young_mask", 64'(ld_fwd_mask[3:0]), 64'hF);
    ld_tail[3:0] = 4'd1;
    #1;
    check("fwd_old_data", 64'(ld_data[31:0]), 64'h11223344);
    cycle();

    // Retire entry0 and hold the D-cache off for three cycles
    ret_count = 1;
    cycle();
    idle();
    repeat (3) begin
      check("hold_valid", 64'(mem_if.mem_req_valid), 64'h1);
      check("hold_addr", 64'(mem_if.mem_req_addr), 64'h100);
      cycle();
    end
    mem_if.mem_req_ready = 1'b1;
    cycle();
    mem_if.mem_req_ready = 1'b0;
    check("drained_valid", 64'(mem_if.mem_req_valid), 64'h0);
    check("drained_empty", 64'(empty), 64'h0);

    // Restore to 5, then to 2 with a same-cycle dispatch that must be ignored
    restore_valid = 1; restore_tail = 4'd5;
    cycle();
    restore_tail = 4'd2; disp_count = 2;
    cycle();
    idle();
    check("restore_tail", 64'(sq_tail), 64'h2);
    res_valid = 1; res_idx = 3; res_addr = 32'h100; res_data = 32'hDEADBEEF; res_mask = 4'hF;
    ld_tail[3:0] = 4'd2;
    ld_addr[31:0] = 32'h100;
    cycle();
    idle();
    check("restore_fwd_data", 64'(ld_data[31:0]), 64'h0000CCDD);
    check("restore_fwd_stall", 64'(ld_stall[0]), 64'h0);
    disp_count = 2;
    cycle();
    idle();
    ld_tail[3:0] = 4'd4;
    #1;
    check("realloc_stall", 64'(ld_stall[0]), 64'h1);
    check("realloc_fwd_mask", 64'(ld_fwd_mask[3:0]), 64'h3);

    // Reset with a committed store pending and no handshake
    ret_count = 1;
    cycle();
    idle();
    check("pending_valid", 64'(mem_if.mem_req_valid), 64'h1);
    reset = 1'b0;
    mem_if.mem_req_ready = 1'b1;
    cycle();
    reset   = 1'b1;
    ld_tail = '0;
    #1;
    check("midrst_valid", 64'(mem_if.mem_req_valid), 64'h0);
    check("midrst_empty", 64'(empty), 64'h1);
    check("midrst_tail", 64'(sq_tail), 64'h0);

    // Randomized traffic, wrapping the pointers many times
    for (int c = 0; c < 3000; c++) begin
      idle();
      sz    = sq.size();
      uncom = sz - n_com;
      retp  = ret_p();
      disp_count = 2'($urandom_range(0, 3));
      mem_if.mem_req_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        res_valid = 1;
        if (uncom > 0 && $urandom_range(0, 3) != 0)
          res_idx = 3'((retp + int'($urandom_range(0, uncom - 1))) % 8);
        else
          res_idx = 3'($urandom_range(0, 7));
        res_addr = pick_addr();
        res_data = $urandom;
        res_mask = 4'($urandom_range(0, 15));
      end
      mr = max_ret();
      ret_count = 2'($urandom_range(0, mr));
      if ($urandom_range(0, 19) == 0) begin
        restore_valid = 1;
        restore_tail = 4'((retp + int'(ret_count) +
                           int'($urandom_range(0, uncom - int'(ret_count)))) % 16);
      end
      for (int p = 0; p < LD_PORTS; p++) begin
        ld_tail[p*4 +: 4]  = 4'((head_p + int'($urandom_range(0, sz))) % 16);
        ld_addr[p*32 +: 32] = pick_addr();
      end
      cycle();
    end
    idle();
    @(negedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
